// File: rtl/dac_wave_gen.sv
// dac_wave_gen: paced AD5681R frame source (hold / sawtooth / triangle).
// A programmable sample timer advances a 12-bit waveform code. One cycle
// after each update, the code is packed into a 24-bit write-and-update
// frame. The frame is then held on a valid/ready handshake until the SPI
// master accepts it.
module dac_wave_gen #(
  parameter int         DIV_W = 16,
  parameter logic [3:0] CMD   = 4'h3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [11:0]      step,
  input  logic [11:0]      min_code,
  input  logic [11:0]      max_code,
  input  logic [DIV_W-1:0] div,
  output logic [23:0]      frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [11:0]      code_out,
  output logic             dir,
  output logic [7:0]       overrun_cnt
);

  logic [DIV_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic             load_pend;
  logic             mode_chg;
  logic             tick;
  logic             degen;
  logic [12:0]      sum;
  logic [12:0]      floor_lim;
  logic [11:0]      code_nxt;
  logic             dir_nxt;

  assign mode_chg = (mode != mode_q);
  // A mode change swallows the tick that would otherwise land this cycle.
  assign tick     = en && !mode_chg && (cnt == div);

  // Next waveform code. All arithmetic is 13 bits wide so that the sum
  // cannot wrap back into the 12-bit range.
  always_comb begin
    sum       = {1'b0, code_out} + {1'b0, step};
    floor_lim = {1'b0, min_code} + {1'b0, step};
    degen     = (min_code >= max_code) || (step == 12'd0);
    code_nxt  = min_code;
    dir_nxt   = 1'b0;
    if (!degen) begin
      case (mode_q)
        2'd1: begin
          code_nxt = (sum > {1'b0, max_code}) ? min_code : sum[11:0];
        end
        2'd2: begin
          if (!dir) begin
            if (sum >= {1'b0, max_code}) begin
              code_nxt = max_code;
              dir_nxt  = 1'b1;
            end else begin
              code_nxt = sum[11:0];
            end
          end else begin
            if ({1'b0, code_out} < floor_lim) begin
              code_nxt = min_code;
              dir_nxt  = 1'b0;
            end else begin
              code_nxt = code_out - step;
              dir_nxt  = 1'b1;
            end
          end
        end
        default: begin
          code_nxt = min_code;
        end
      endcase
    end
  end

  // Sample timer, mode register and waveform state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      mode_q   <= mode;
      code_out <= min_code;
      dir      <= 1'b0;
    end else if (mode_chg) begin
      mode_q   <= mode;
      cnt      <= '0;
      code_out <= min_code;
      dir      <= 1'b0;
    end else if (en) begin
      if (cnt == div) begin
        cnt      <= '0;
        code_out <= code_nxt;
        dir      <= dir_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Frame packing and handshake. A load issued in the same cycle as an
  // accepted transfer takes priority, so the new frame goes out back to back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_pend   <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= 24'h0;
      overrun_cnt <= 8'h00;
    end else begin
      load_pend <= tick;
      if (load_pend) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= {CMD, code_out, 8'h00};
          frame_valid <= 1'b1;
        end else if (overrun_cnt != 8'hFF) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
